// File: rtl/n64_ctrl_sniffer_mp.sv
// Passive multi-port N64 joybus sniffer: decodes poll/status responses per port,
// hands poll frames over via toggle-ack handshakes and raises an IGR console reset.
module n64_ctrl_sniffer_mp #(
  parameter int unsigned NUM_PORTS = 1,
  parameter int unsigned CNT_W     = 8,
  parameter logic [15:0] IGR_COMBO = 16'h0000,
  parameter logic [19:0] RST_LEN   = 20'hFFFFF
) (
  input  logic                     CTRL_CLK,
  input  logic                     CTRL_RST,
  input  logic [NUM_PORTS-1:0]     CTRL_i,
  input  logic [NUM_PORTS-1:0]     igr_en_i,
  output logic [32*NUM_PORTS-1:0]  ctrl_data_o,
  output logic [24*NUM_PORTS-1:0]  status_o,
  output logic [NUM_PORTS-1:0]     new_data_o,
  input  logic [NUM_PORTS-1:0]     ack_i,
  output logic [NUM_PORTS-1:0]     overrun_o,
  output logic [NUM_PORTS-1:0]     detected_o,
  output logic                     drv_rst_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CMD,
    S_RESP_POLL,
    S_RESP_STAT
  } state_t;

  localparam logic [CNT_W-1:0] SAT = '1;

  logic [NUM_PORTS-1:0] igr_en_s0;
  logic [NUM_PORTS-1:0] igr_en_s1;
  logic [NUM_PORTS-1:0] igr_hit;
  logic [19:0]          rst_cnt;

  always_ff @(posedge CTRL_CLK or posedge CTRL_RST) begin
    if (CTRL_RST) begin
      igr_en_s0 <= '0;
      igr_en_s1 <= '0;
    end else begin
      igr_en_s0 <= igr_en_i;
      igr_en_s1 <= igr_en_s0;
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic [2:0]       hist;
    logic [2:0]       ack_sh;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] lo_len;
    state_t           state, state_nxt;
    logic [31:0]      sr, sr_nxt;
    logic [5:0]       bcnt, bcnt_nxt;
    logic             fall, rise, bit_val, sat, ack_pulse;
    logic             poll_done, stat_done, no_resp;
    logic [31:0]      data_q;
    logic [23:0]      stat_q;
    logic             new_q, ovr_q, det_q;

    assign fall      = hist[2] & ~hist[1];
    assign rise      = ~hist[2] & hist[1];
    assign bit_val   = lo_len < cnt;
    assign sat       = (cnt == SAT);
    assign ack_pulse = ack_sh[2] ^ ack_sh[1];

    always_ff @(posedge CTRL_CLK or posedge CTRL_RST) begin
      if (CTRL_RST) begin
        hist   <= '1;
        ack_sh <= '0;
        cnt    <= '0;
        lo_len <= '0;
      end else begin
        hist   <= {hist[1:0], CTRL_i[p]};
        ack_sh <= {ack_sh[1:0], ack_i[p]};
        if (fall | rise)
          cnt <= '0;
        else if (!sat)
          cnt <= cnt + CNT_W'(1);
        if (rise)
          lo_len <= cnt;
      end
    end

    always_ff @(posedge CTRL_CLK or posedge CTRL_RST) begin
      if (CTRL_RST) begin
        state <= S_IDLE;
        sr    <= '0;
        bcnt  <= '0;
      end else begin
        state <= state_nxt;
        sr    <= sr_nxt;
        bcnt  <= bcnt_nxt;
      end
    end

    // The 9th command negedge samples the console stop bit; it only triggers the decode.
    always_comb begin
      state_nxt = state;
      sr_nxt    = sr;
      bcnt_nxt  = bcnt;
      poll_done = 1'b0;
      stat_done = 1'b0;
      no_resp   = 1'b0;
      case (state)
        S_IDLE: begin
          if (fall && sat) begin
            state_nxt = S_CMD;
            sr_nxt    = '0;
            bcnt_nxt  = '0;
          end
        end
        S_CMD: begin
          if (sat) begin
            state_nxt = S_IDLE;
            no_resp   = 1'b1;
          end else if (fall) begin
            if (bcnt == 6'd8) begin
              sr_nxt   = '0;
              bcnt_nxt = '0;
              case (sr[7:0])
                8'h01:        state_nxt = S_RESP_POLL;
                8'h00, 8'hFF: state_nxt = S_RESP_STAT;
                default:      state_nxt = S_IDLE;
              endcase
            end else begin
              sr_nxt   = {sr[30:0], bit_val};
              bcnt_nxt = bcnt + 6'd1;
            end
          end
        end
        S_RESP_POLL: begin
          if (sat) begin
            state_nxt = S_IDLE;
          end else if (fall) begin
            sr_nxt   = {bit_val, sr[31:1]};
            bcnt_nxt = bcnt + 6'd1;
            if (bcnt == 6'd31) begin
              poll_done = 1'b1;
              state_nxt = S_IDLE;
            end
          end
        end
        S_RESP_STAT: begin
          if (sat) begin
            state_nxt = S_IDLE;
          end else if (fall) begin
            sr_nxt   = {8'h00, bit_val, sr[23:1]};
            bcnt_nxt = bcnt + 6'd1;
            if (bcnt == 6'd23) begin
              stat_done = 1'b1;
              state_nxt = S_IDLE;
            end
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end

    // A completing frame beats a coincident ack: data stays flagged, overrun is cleared.
    always_ff @(posedge CTRL_CLK or posedge CTRL_RST) begin
      if (CTRL_RST) begin
        data_q <= '0;
        stat_q <= '0;
        new_q  <= 1'b0;
        ovr_q  <= 1'b0;
        det_q  <= 1'b0;
      end else begin
        if (poll_done) begin
          data_q <= sr_nxt;
          new_q  <= 1'b1;
          ovr_q  <= ack_pulse ? 1'b0 : (ovr_q | new_q);
        end else if (ack_pulse) begin
          new_q <= 1'b0;
          ovr_q <= 1'b0;
        end
        if (stat_done)
          stat_q <= sr_nxt[23:0];
        if (poll_done | stat_done)
          det_q <= 1'b1;
        else if (no_resp)
          det_q <= 1'b0;
      end
    end

    assign igr_hit[p]              = poll_done & igr_en_s1[p] & (sr_nxt[15:0] == IGR_COMBO);
    assign ctrl_data_o[32*p +: 32] = data_q;
    assign status_o[24*p +: 24]    = stat_q;
    assign new_data_o[p]           = new_q;
    assign overrun_o[p]            = ovr_q;
    assign detected_o[p]           = det_q;
  end

  always_ff @(posedge CTRL_CLK or posedge CTRL_RST) begin
    if (CTRL_RST) begin
      drv_rst_o <= 1'b0;
      rst_cnt   <= '0;
    end else if (|igr_hit) begin
      drv_rst_o <= 1'b1;
      rst_cnt   <= RST_LEN;
    end else if (rst_cnt != '0) begin
      rst_cnt <= rst_cnt - 20'd1;
    end else begin
      drv_rst_o <= 1'b0;
    end
  end

endmodule
